systolic_seq_ctrl: RTL and testbench

Sequencer for an N x N output-stationary systolic array of pipelined MAC PEs. Each PE has three stages: input register, multiply, accumulate.
- Clears the accumulators and streams K operand pairs with row/column skew.
- Flushes the PE pipeline, then drains N result rows over a valid/ready interface.
- Sits between the operand skew buffers, the array, and the result writeback.

---
 rtl/systolic_seq_ctrl_pkg.sv | 24 ++
 rtl/systolic_seq_ctrl_if.sv | 36 +++
 rtl/systolic_seq_ctrl_skew_mask.sv | 20 ++
 rtl/systolic_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

    // PE pipeline: input register, multiply, accumulate.
    localparam int PE_LAT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DRAIN,
        DONE
    } state_t;

    // Cycles needed after the last stream step for the final operand pair
    // to land in the accumulator of PE(N-1,N-1).
    function automatic int flush_len(input int n);
        return n + PE_LAT - 2;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Control/handshake bundle between sequencer, skew buffers, array and writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid stalls streaming, drain_ready stalls result drain.
// master: job/operand/writeback side (drives start, cfg_k, in_valid, drain_ready).
// slave : sequencer side (drives busy, done, array controls, drain and perf outputs).
interface systolic_seq_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 16
) ();
    logic                 start;
    logic [KW-1:0]        cfg_k;
    logic                 in_valid;
    logic                 drain_ready;
    logic                 busy;
    logic                 done;
    logic                 arr_ce;
    logic                 arr_load_acc;
    logic [N-1:0]         feed_en;
    logic [KW:0]          stream_t;
    logic                 drain_valid;
    logic [$clog2(N)-1:0] drain_row;
    logic [31:0]          perf_cycles;
    logic [31:0]          perf_stalls;

    modport master (
        output start, cfg_k, in_valid, drain_ready,
        input  busy, done, arr_ce, arr_load_acc, feed_en, stream_t,
               drain_valid, drain_row, perf_cycles, perf_stalls
    );

    modport slave (
        input  start, cfg_k, in_valid, drain_ready,
        output busy, done, arr_ce, arr_load_acc, feed_en, stream_t,
               drain_valid, drain_row, perf_cycles, perf_stalls
    );
endinterface

// File: rtl/systolic_seq_ctrl_skew_mask.sv
// Skew mask: lane i is live for stream steps i <= t < k+i.
// Latency: combinational.
// Backpressure: none; follows t, which the caller holds during stalls.
// Ports: t (stream step, KW+1 bits), k (reduction length), feed_en (one bit per lane).
module systolic_skew_mask #(
    parameter int N  = 4,
    parameter int KW = 16
) (
    input  logic [KW:0]   t,
    input  logic [KW-1:0] k,
    output logic [N-1:0]  feed_en
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [KW:0] IDX = (KW+1)'(i);
        logic [KW:0] hi;
        // k+i at KW+1 bits cannot overflow for any KW-bit k and small N.
        assign hi         = {1'b0, k} + IDX;
        assign feed_en[i] = (t >= IDX) && (t < hi);
    end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array: clear, skewed stream, flush, row drain.
// Latency: 1 clear + (k+N-1 stream steps + N+1 flush when k>0) + N drain beats + 1 done cycle.
// Backpressure: in_valid=0 freezes stream step and array; drain_ready=0 holds the current row.
// Ports: clk, rst (sync, active-high), bus (systolic_seq_ctrl_if.slave).
// Optional macro SYSTOLIC_SEQ_CTRL_PERF_EN enables saturating perf_cycles/perf_stalls counters.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int KW = 16
) (
    input  logic           clk,
    input  logic           rst,
    systolic_seq_ctrl_if.slave bus
);
    localparam int              FL       = flush_len(N);
    localparam int              FW       = $clog2(FL + 1);
    localparam int              RW       = $clog2(N);
    localparam logic [FW-1:0]   FL_LAST  = FW'(FL - 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(N - 1);
    localparam logic [KW:0]     SKEW     = (KW+1)'(N - 2);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [KW:0]     t_q, t_d;
    logic [FW-1:0]   fl_q, fl_d;
    logic [RW-1:0]   row_q, row_d;
    logic [KW:0]     t_last;
    logic [N-1:0]    mask;
    logic            start_acc;

    // Last stream step index, k+N-2, kept at KW+1 bits so k=2^KW-1 fits.
    assign t_last    = {1'b0, k_q} + SKEW;
    assign start_acc = (state_q == IDLE) && bus.start;

    systolic_skew_mask #(.N(N), .KW(KW)) u_mask (
        .t       (t_q),
        .k       (k_q),
        .feed_en (mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            t_q     <= '0;
            fl_q    <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            fl_q    <= fl_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        fl_d    = fl_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    k_d     = bus.cfg_k;
                    t_d     = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                fl_d    = '0;
                row_d   = '0;
                state_d = (k_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                if (bus.in_valid) begin
                    t_d = t_q + (KW+1)'(1);
                    if (t_q == t_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (fl_q == FL_LAST) begin
                    state_d = DRAIN;
                end else begin
                    fl_d = fl_q + FW'(1);
                end
            end
            DRAIN: begin
                if (bus.drain_ready) begin
                    if (row_q == ROW_LAST) begin
                        row_d   = '0;
                        state_d = DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything except arr_ce in STREAM is decoded from flops only.
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.arr_load_acc = (state_q == CLEAR);
    assign bus.arr_ce       = (state_q == CLEAR) || (state_q == FLUSH) ||
                              ((state_q == STREAM) && bus.in_valid);
    assign bus.feed_en      = (state_q == STREAM) ? mask : '0;
    assign bus.stream_t     = t_q;
    assign bus.drain_valid  = (state_q == DRAIN);
    assign bus.drain_row    = row_q;

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    logic [31:0] cyc_q, cyc_d, stl_q, stl_d;

    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        if (start_acc) begin
            cyc_d = '0;
            stl_d = '0;
        end else begin
            if ((state_q != IDLE) && (cyc_q != '1)) begin
                cyc_d = cyc_q + 32'd1;
            end
            if ((state_q == STREAM) && !bus.in_valid && (stl_q != '1)) begin
                stl_d = stl_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            stl_q <= stl_d;
        end
    end

    assign bus.perf_cycles = cyc_q;
    assign bus.perf_stalls = stl_q;
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_stalls = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Testbench for systolic_seq_ctrl: job table with per-cycle timeline checks and a drain-row scoreboard.
// Latency: n/a.
// Backpressure: exercises in_valid stalls and drain_ready gaps.
module tb_systolic_seq_ctrl;
    localparam int N  = 4;
    localparam int KW = 16;
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_seq_ctrl_if #(.N(N), .KW(KW)) bus ();

    systolic_seq_ctrl #(.N(N), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int         k;
        int         sa;        // stream step at which the stall starts
        int         sl;        // stall length in cycles
        logic [7:0] rp;        // drain_ready for the first 8 drain cycles, bit0 first
        bit         poke;      // pulse start with a different cfg_k mid-stream
        int         exp_done;  // cycle of the done pulse, start cycle = 0
        int         exp_stalls;
    } job_t;

    job_t jobs[7];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   exp_rows[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_mask(input int t, input int k);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (t >= i) && (t < k + i);
        return m;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     64'(bus.busy), 0);
        check({tag, "_done"},     64'(bus.done), 0);
        check({tag, "_ce"},       64'(bus.arr_ce), 0);
        check({tag, "_load"},     64'(bus.arr_load_acc), 0);
        check({tag, "_feed"},     64'(bus.feed_en), 0);
        check({tag, "_t"},        64'(bus.stream_t), 0);
        check({tag, "_dvld"},     64'(bus.drain_valid), 0);
        check({tag, "_drow"},     64'(bus.drain_row), 0);
        check({tag, "_pcyc"},     64'(bus.perf_cycles), 0);
        check({tag, "_pstl"},     64'(bus.perf_stalls), 0);
    endtask

    task automatic run_job(input job_t j);
        int se, ds, exp_t, off, done_seen;
        bit in_stream, in_flush, in_drain;
        se = (j.k > 0) ? 2 + j.k + N - 2 + j.sl : 1;
        ds = (j.k > 0) ? se + N + 2 : 2;
        exp_rows.delete();
        for (int r = 0; r < N; r++) exp_rows.push_back(r);
        bus.start = 1'b1;
        bus.cfg_k = j.k[KW-1:0];
        cyc       = 0;
        done_seen = -1;
        #1;
        check("idle_busy", 64'(bus.busy), 0);
        while ((cyc < j.exp_done + 20) && (done_seen < 0)) begin
            @(posedge clk);
            #1;
            cyc++;
            if (j.poke && cyc == 5) begin
                bus.start = 1'b1;
                bus.cfg_k = KW'(2);
            end else begin
                bus.start = 1'b0;
                bus.cfg_k = KW'($urandom);
            end
            in_stream = (j.k > 0) && (cyc >= 2) && (cyc <= se);
            in_flush  = (j.k > 0) && (cyc > se) && (cyc < ds);
            in_drain  = (cyc >= ds) && (cyc < j.exp_done);
            if (in_stream) bus.in_valid = !((cyc >= 2 + j.sa) && (cyc < 2 + j.sa + j.sl));
            else           bus.in_valid = 1'($urandom_range(0, 1));
            if (cyc >= ds && cyc - ds < 8) bus.drain_ready = j.rp[cyc-ds];
            else if (cyc >= ds)            bus.drain_ready = 1'b1;
            else                           bus.drain_ready = 1'($urandom_range(0, 1));
            #1;
            check("busy",   64'(bus.busy), 64'(cyc <= j.exp_done));
            check("done",   64'(bus.done), 64'(cyc == j.exp_done));
            check("load",   64'(bus.arr_load_acc), 64'(cyc == 1));
            check("arr_ce", 64'(bus.arr_ce),
                  64'((cyc == 1) || in_flush || (in_stream && bus.in_valid)));
            check("dvld",   64'(bus.drain_valid), 64'(in_drain));
            if (in_stream) begin
                off   = cyc - 2;
                exp_t = (off < j.sa) ? off : ((off < j.sa + j.sl) ? j.sa : off - j.sl);
                check("stream_t", 64'(bus.stream_t), 64'(exp_t));
                check("feed_en",  64'(bus.feed_en), 64'(ref_mask(exp_t, j.k)));
                if (j.k == 8) begin
                    case (exp_t)
                        0:  check("feed_t0",  64'(bus.feed_en), 64'(4'b0001));
                        3:  check("feed_t3",  64'(bus.feed_en), 64'(4'b1111));
                        8:  check("feed_t8",  64'(bus.feed_en), 64'(4'b1110));
                        10: check("feed_t10", 64'(bus.feed_en), 64'(4'b1000));
                        default: ;
                    endcase
                end
            end else begin
                check("feed_off", 64'(bus.feed_en), 0);
            end
            if (bus.drain_valid && bus.drain_ready) begin
                if (exp_rows.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat cyc=%0d got=row%0d want=none", cyc, bus.drain_row);
                end else begin
                    check("drain_row", 64'(bus.drain_row), 64'(exp_rows.pop_front()));
                end
            end
            if (bus.done) done_seen = cyc;
        end
        check("done_cycle", 64'(done_seen), 64'(j.exp_done));
        check("rows_left",  64'(exp_rows.size()), 0);
        @(posedge clk);
        #1;
        cyc++;
        check("post_busy", 64'(bus.busy), 0);
        check("post_done", 64'(bus.done), 0);
        check("perf_cyc",  64'(bus.perf_cycles), PERF ? 64'(j.exp_done) : 0);
        check("perf_stl",  64'(bus.perf_stalls), PERF ? 64'(j.exp_stalls) : 0);
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        check("hold_cyc",  64'(bus.perf_cycles), PERF ? 64'(j.exp_done) : 0);
        check("hold_stl",  64'(bus.perf_stalls), PERF ? 64'(j.exp_stalls) : 0);
    endtask

    initial begin
        //          k      sa  sl  rp            poke  done   stalls
        jobs[0] = '{8,     0,  0,  8'b1111_1111, 1'b0, 22,    0};
        jobs[1] = '{8,     5,  3,  8'b1111_1111, 1'b0, 25,    3};
        jobs[2] = '{0,     0,  0,  8'b1111_1111, 1'b0, 6,     0};
        jobs[3] = '{8,     0,  0,  8'b1111_0010, 1'b0, 25,    0};
        jobs[4] = '{1,     0,  0,  8'b1111_1111, 1'b1, 15,    0};
        jobs[5] = '{3,     0,  2,  8'b1111_0110, 1'b0, 21,    2};
        jobs[6] = '{65535, 0,  0,  8'b1111_1111, 1'b0, 65549, 0};

        bus.start       = 1'b0;
        bus.cfg_k       = '0;
        bus.in_valid    = 1'b1;
        bus.drain_ready = 1'b1;
        rst             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        // Reset in the middle of streaming, then confirm a fresh job runs cleanly.
        bus.start    = 1'b1;
        bus.cfg_k    = KW'(8);
        bus.in_valid = 1'b1;
        cyc          = 0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cyc = 6;
        check("pre_rst_t",  64'(bus.stream_t), 4);
        check("pre_rst_ce", 64'(bus.arr_ce), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check("midrst_idle", 64'(bus.busy), 0);
        run_job(jobs[0]);

        run_job(jobs[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
